weight_stream_loader: RTL

Write-side loader for the per-neuron weight memories. It accepts a framed 32-bit valid/ready word stream from the PS/DMA side: one header word, then N weight words. It converts the stream into single-cycle write strobes (`wen`, `waddr`, `wdata`) plus a layer/neuron select that the memory write ports and the neuron select decode consume. It sits between the AXI-facing configuration logic and the weight memories, whose read port is driven by the neuron datapath.

---
 rtl/weight_stream_loader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: turns a framed valid/ready word stream (one header
// word followed by N weight words) into single-cycle weight-memory write
// strobes, and latches the layer/neuron select carried by the header.
module weight_stream_loader #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic                    wen,
  output logic [addressWidth-1:0] waddr,
  output logic [dataWidth-1:0]    wdata,
  output logic [7:0]              layer_no,
  output logic [7:0]              neuron_no,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // The beat counter carries one extra bit so a full 2**addressWidth frame
  // can be counted without wrapping.
  localparam int CW = addressWidth + 1;
  localparam logic [31:0] MAX_FRAME = 32'd1 << addressWidth;
  localparam logic [CW-1:0] ONE = {{addressWidth{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic                    r_ready;
  logic                    r_wen;
  logic [addressWidth-1:0] r_waddr;
  logic [dataWidth-1:0]    r_wdata;
  logic [7:0]              r_layer;
  logic [7:0]              r_neuron;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [CW-1:0]           r_last_idx;
  logic [CW-1:0]           r_beat;

  logic                    w_xfer;
  logic [31:0]             w_hdr_count;
  logic                    w_hdr_bad;
  logic                    w_last_beat;

  logic                    w_ready_next;
  logic                    w_wen_next;
  logic [addressWidth-1:0] w_waddr_next;
  logic [dataWidth-1:0]    w_wdata_next;
  logic [7:0]              w_layer_next;
  logic [7:0]              w_neuron_next;
  logic                    w_busy_next;
  logic                    w_done_next;
  logic                    w_err_next;
  logic [CW-1:0]           w_last_idx_next;
  logic [CW-1:0]           w_beat_next;

  assign w_xfer      = s_valid && r_ready;
  assign w_hdr_count = {16'd0, s_data[15:0]};
  // A header is rejected for an empty or oversize frame, or if it claims to
  // be the final beat of a frame that still expects weights.
  assign w_hdr_bad   = (w_hdr_count == 32'd0) || (w_hdr_count > MAX_FRAME) || s_last;
  assign w_last_beat = (r_beat == r_last_idx);

  // State register only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-output decode; every output is registered below so
  // s_ready never depends combinationally on s_valid.
  always_comb begin
    w_state_next    = r_state;
    w_wen_next      = 1'b0;
    w_waddr_next    = r_waddr;
    w_wdata_next    = r_wdata;
    w_layer_next    = r_layer;
    w_neuron_next   = r_neuron;
    w_err_next      = 1'b0;
    w_last_idx_next = r_last_idx;
    w_beat_next     = r_beat;

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_hdr_bad) begin
            w_err_next = 1'b1;
          end else begin
            w_layer_next    = s_data[31:24];
            w_neuron_next   = s_data[23:16];
            w_last_idx_next = w_hdr_count[CW-1:0] - ONE;
            w_beat_next     = '0;
            w_state_next    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_wen_next   = 1'b1;
          w_waddr_next = r_beat[addressWidth-1:0];
          w_wdata_next = s_data[dataWidth-1:0];
          w_beat_next  = r_beat + ONE;
          if (w_last_beat) begin
            // Frame is complete regardless; a missing s_last is still flagged.
            w_err_next   = !s_last;
            w_state_next = S_DONE;
          end else if (s_last) begin
            // Early termination: keep what was written, abandon the frame.
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_ready_next = (w_state_next != S_DONE);
    w_busy_next  = (w_state_next == S_LOAD);
    w_done_next  = (w_state_next == S_DONE);
  end

  // Output and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_layer    <= '0;
      r_neuron   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_last_idx <= '0;
      r_beat     <= '0;
    end else begin
      r_ready    <= w_ready_next;
      r_wen      <= w_wen_next;
      r_waddr    <= w_waddr_next;
      r_wdata    <= w_wdata_next;
      r_layer    <= w_layer_next;
      r_neuron   <= w_neuron_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_last_idx <= w_last_idx_next;
      r_beat     <= w_beat_next;
    end
  end

  assign s_ready   = r_ready;
  assign wen       = r_wen;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign layer_no  = r_layer;
  assign neuron_no = r_neuron;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
